// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: ROM geometry defaults and FSM states.
// Imported by program_loader and its byte packer.
package program_loader_pkg;

   localparam int ROM_ADDR_WIDTH_DEF = 8;
   localparam int ROM_DATA_WIDTH_DEF = 16;
   localparam int RELEASE_CYCLES_DEF = 2;

   typedef enum logic [2:0] {
      HALT    = 3'd0,
      LOAD    = 3'd1,
      WRITE   = 3'd2,
      RELEASE = 3'd3,
      RUN     = 3'd4
   } state_t;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Packs host bytes MSB-first into one instruction word.
// Ports: clk, arst, accept/clear controls, data byte in; word, word_full out.
module program_loader_byte_packer
   import program_loader_pkg::*;
#(
   parameter int DATA_WIDTH = ROM_DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  accept,
   input  logic                  clear,
   input  logic [7:0]            data,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_full
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

   logic [IW-1:0] idx_q;

   // word_full flags the byte that completes the word, in its accept cycle
   assign word_full = accept & (idx_q == LAST);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         word  <= '0;
         idx_q <= '0;
      end else if (clear) begin
         idx_q <= '0;
      end else if (accept) begin
         word  <= (word << 8) | DATA_WIDTH'(data);
         idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot/reload sequencer: holds the core in reset, streams host bytes into
// instruction memory as words from address 0, then releases the core.
// Ports: clk, arst; load_start/load_len/load_abort control; s_data/s_valid/
// s_ready host byte link; pmem_addr/pmem_data/pmem_we memory write port;
// cpu_rst core reset; busy, done pulse, sticky err status.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ROM_ADDR_WIDTH = ROM_ADDR_WIDTH_DEF,
   parameter int ROM_DATA_WIDTH = ROM_DATA_WIDTH_DEF,
   parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEF
) (
   input  logic                      clk,
   input  logic                      arst,
   input  logic                      load_start,
   input  logic [ROM_ADDR_WIDTH:0]   load_len,
   input  logic                      load_abort,
   input  logic [7:0]                s_data,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic [ROM_ADDR_WIDTH-1:0] pmem_addr,
   output logic [ROM_DATA_WIDTH-1:0] pmem_data,
   output logic                      pmem_we,
   output logic                      cpu_rst,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam int AW = ROM_ADDR_WIDTH;
   localparam int RW = $clog2(RELEASE_CYCLES + 1);
   localparam logic [AW:0]   DEPTH    = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   ONE      = {{AW{1'b0}}, 1'b1};
   localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);

   state_t state_q, state_d;

   logic [AW-1:0] word_idx_q;
   logic [AW:0]   len_q;
   logic [AW:0]   word_nxt;
   logic [RW-1:0] rel_cnt_q;
   logic          done_q;
   logic          err_q;

   logic idle;
   logic start_ok;
   logic len_bad;
   logic abort_act;
   logic accept;
   logic last_word;
   logic word_full;
   logic pk_clear;

   assign idle      = (state_q == HALT) | (state_q == RUN);
   // abort beats a simultaneous start
   assign start_ok  = load_start & idle & ~load_abort;
   assign len_bad   = load_len > DEPTH;
   assign abort_act = load_abort &
                      ((state_q == LOAD) | (state_q == WRITE));
   // ready drops on abort so the aborted cycle consumes no byte
   assign s_ready   = (state_q == LOAD) & ~load_abort;
   assign accept    = s_valid & s_ready;
   // extra bit lets a full-depth load terminate on wrap
   assign word_nxt  = {1'b0, word_idx_q} + ONE;
   assign last_word = word_nxt == len_q;
   assign pk_clear  = start_ok | abort_act | (state_q == WRITE);

   program_loader_byte_packer #(
      .DATA_WIDTH (ROM_DATA_WIDTH)
   ) u_packer (
      .clk       (clk),
      .arst      (arst),
      .accept    (accept),
      .clear     (pk_clear),
      .data      (s_data),
      .word      (pmem_data),
      .word_full (word_full)
   );

   assign pmem_we   = state_q == WRITE;
   assign pmem_addr = word_idx_q;
   assign cpu_rst   = state_q != RUN;
   assign busy      = ~idle;
   assign done      = done_q;
   assign err       = err_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         HALT, RUN: begin
            if (start_ok) begin
               if (len_bad)
                  state_d = HALT;
               else if (load_len == '0)
                  state_d = RELEASE;
               else
                  state_d = LOAD;
            end
         end
         LOAD: begin
            if (load_abort)
               state_d = HALT;
            else if (word_full)
               state_d = WRITE;
         end
         WRITE: begin
            if (load_abort)
               state_d = HALT;
            else if (last_word)
               state_d = RELEASE;
            else
               state_d = LOAD;
         end
         RELEASE: begin
            if (rel_cnt_q == REL_LAST)
               state_d = RUN;
         end
         default: state_d = HALT;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q    <= HALT;
         word_idx_q <= '0;
         len_q      <= '0;
         rel_cnt_q  <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == RELEASE) & (state_d == RUN);

         if (start_ok) begin
            if (len_bad) begin
               err_q <= 1'b1;
            end else begin
               err_q      <= 1'b0;
               len_q      <= load_len;
               word_idx_q <= '0;
            end
         end else if (abort_act) begin
            err_q <= 1'b1;
         end

         if (state_q == WRITE)
            word_idx_q <= word_nxt[AW-1:0];

         if (state_q == RELEASE)
            rel_cnt_q <= rel_cnt_q + 1'b1;
         else
            rel_cnt_q <= '0;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: load, gaps, reload, abort, bounds.
// Write port activity is captured by a monitor and checked per scenario.
module tb_program_loader;

   logic        clk;
   logic        arst;
   logic        load_start;
   logic [8:0]  load_len;
   logic        load_abort;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  pmem_addr;
   logic [15:0] pmem_data;
   logic        pmem_we;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        err;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0]  wa[$];
   logic [15:0] wd[$];
   int          wc[$];
   int          done_cyc  = -1;
   int          fall_cyc  = -1;
   int          rdy_in_wr = 0;
   logic        prev_rst  = 1'b1;
   logic [7:0]  tx[$];
   int          start_cyc;
   int          first_acc;

   program_loader dut (
      .clk        (clk),
      .arst       (arst),
      .load_start (load_start),
      .load_len   (load_len),
      .load_abort (load_abort),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .pmem_addr  (pmem_addr),
      .pmem_data  (pmem_data),
      .pmem_we    (pmem_we),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (pmem_we === 1'b1) begin
         wa.push_back(pmem_addr);
         wd.push_back(pmem_data);
         wc.push_back(cyc);
         if (s_ready !== 1'b0) rdy_in_wr = rdy_in_wr + 1;
      end
      if (done === 1'b1) done_cyc = cyc;
      if (prev_rst === 1'b1 && cpu_rst === 1'b0) fall_cyc = cyc;
      prev_rst = cpu_rst;
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
      wc.delete();
      done_cyc  = -1;
      fall_cyc  = -1;
      rdy_in_wr = 0;
   endtask

   task automatic start(input logic [8:0] len);
      load_start = 1'b1;
      load_len   = len;
      start_cyc  = cyc;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send_bytes(input bit gappy);
      int i = 0;
      int t = 0;
      bit ph = 1'b1;
      first_acc = -1;
      while (i < tx.size() && t < 4000) begin
         s_valid = gappy ? ph : 1'b1;
         s_data  = tx[i];
         ph      = ~ph;
         #1;
         if (s_valid && s_ready) begin
            if (first_acc < 0) first_acc = cyc;
            i++;
         end
         tick();
         t++;
      end
      s_valid = 1'b0;
      n_assert++;
      if (i != tx.size()) begin
         n_fail++;
         $display("FAIL send_bytes: sent %0d of %0d bytes", i, tx.size());
      end
   endtask

   task automatic wait_done();
      int t = 0;
      while (done_cyc < 0 && t < 50) begin
         tick();
         t++;
      end
      n_assert++;
      if (done_cyc < 0) begin
         n_fail++;
         $display("FAIL wait_done: no done pulse within 50 cycles");
      end
   endtask

   task automatic check_three(input bit gappy);
      logic [15:0] exp_d [3];
      exp_d[0] = 16'h1234;
      exp_d[1] = 16'h5678;
      exp_d[2] = 16'h9ABC;
      n_assert++;
      if (wa.size() != 3) begin
         n_fail++;
         $display("FAIL write_count: got %0d expected 3", wa.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (wa[k] !== 8'(k) || wd[k] !== exp_d[k]) begin
               n_fail++;
               $display("FAIL write%0d: got %h/%h expected %h/%h",
                        k, wa[k], wd[k], 8'(k), exp_d[k]);
            end
         end
         if (!gappy) begin
            n_assert++;
            if (wc[0] - first_acc != 2) begin
               n_fail++;
               $display("FAIL first_latency: got %0d expected 2",
                        wc[0] - first_acc);
            end
            n_assert++;
            if (wc[1] - wc[0] != 3 || wc[2] - wc[1] != 3) begin
               n_fail++;
               $display("FAIL spacing: got %0d,%0d expected 3,3",
                        wc[1] - wc[0], wc[2] - wc[1]);
            end
         end
         n_assert++;
         if (fall_cyc - wc[2] != 3) begin
            n_fail++;
            $display("FAIL release_delay: got %0d expected 3",
                     fall_cyc - wc[2]);
         end
      end
      n_assert++;
      if (done_cyc != fall_cyc) begin
         n_fail++;
         $display("FAIL done_align: done %0d cpu_rst fall %0d",
                  done_cyc, fall_cyc);
      end
      n_assert++;
      if (rdy_in_wr != 0) begin
         n_fail++;
         $display("FAIL ready_in_write: got %0d expected 0", rdy_in_wr);
      end
      n_assert++;
      if (cpu_rst !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL run_state: cpu_rst %b busy %b expected 0 0",
                  cpu_rst, busy);
      end
   endtask

   task automatic test_reset();
      arst       = 1'b1;
      load_start = 1'b0;
      load_len   = '0;
      load_abort = 1'b0;
      s_data     = '0;
      s_valid    = 1'b0;
      tick();
      tick();
      arst = 1'b0;
      clear_log();
      for (int k = 0; k < 20; k++) tick();
      n_assert++;
      if (cpu_rst !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: cpu_rst %b busy %b err %b expected 1 0 0",
                  cpu_rst, busy, err);
      end
      n_assert++;
      if (s_ready !== 1'b0 || done !== 1'b0 || pmem_addr !== 8'h00 ||
          pmem_data !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_out: ready %b done %b addr %h data %h",
                  s_ready, done, pmem_addr, pmem_data);
      end
      n_assert++;
      if (wa.size() != 0) begin
         n_fail++;
         $display("FAIL reset_we: got %0d writes expected 0", wa.size());
      end
   endtask

   task automatic test_basic_load();
      clear_log();
      tx = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
      start(9'd3);
      send_bytes(1'b0);
      wait_done();
      tick();
      check_three(1'b0);
   endtask

   task automatic test_gaps();
      clear_log();
      tx = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
      start(9'd3);
      send_bytes(1'b1);
      wait_done();
      tick();
      check_three(1'b1);
   endtask

   task automatic test_reload();
      clear_log();
      tx = '{8'hAA, 8'h55};
      start(9'd1);
      n_assert++;
      if (cpu_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL reload_rst: got %b expected 1", cpu_rst);
      end
      send_bytes(1'b0);
      wait_done();
      tick();
      n_assert++;
      if (wa.size() != 1) begin
         n_fail++;
         $display("FAIL reload_count: got %0d expected 1", wa.size());
      end else begin
         n_assert++;
         if (wa[0] !== 8'h00 || wd[0] !== 16'hAA55) begin
            n_fail++;
            $display("FAIL reload_write: got %h/%h expected 00/aa55",
                     wa[0], wd[0]);
         end
      end
      n_assert++;
      if (cpu_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL reload_run: cpu_rst %b expected 0", cpu_rst);
      end
   endtask

   task automatic test_abort();
      clear_log();
      tx = '{8'h11};
      start(9'd2);
      send_bytes(1'b0);
      load_abort = 1'b1;
      tick();
      load_abort = 1'b0;
      n_assert++;
      if (busy !== 1'b0 || err !== 1'b1 || cpu_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_state: busy %b err %b cpu_rst %b expected 0 1 1",
                  busy, err, cpu_rst);
      end
      tx = '{8'h22, 8'h33};
      s_valid = 1'b1;
      s_data  = 8'h22;
      for (int k = 0; k < 5; k++) tick();
      s_valid = 1'b0;
      n_assert++;
      if (wa.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_writes: got %0d writes busy %b expected 0 0",
                  wa.size(), busy);
      end
      clear_log();
      start(9'd0);
      n_assert++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_len_start: err %b busy %b expected 0 1",
                  err, busy);
      end
      wait_done();
      tick();
      n_assert++;
      if (fall_cyc - start_cyc != 3 || done_cyc != fall_cyc) begin
         n_fail++;
         $display("FAIL zero_len_release: fall %0d done %0d start %0d",
                  fall_cyc, done_cyc, start_cyc);
      end
      n_assert++;
      if (cpu_rst !== 1'b0 || wa.size() != 0) begin
         n_fail++;
         $display("FAIL zero_len_run: cpu_rst %b writes %0d expected 0 0",
                  cpu_rst, wa.size());
      end
   endtask

   task automatic test_bounds();
      int bad = 0;
      clear_log();
      start(9'd257);
      n_assert++;
      if (err !== 1'b1 || busy !== 1'b0 || cpu_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL len257: err %b busy %b cpu_rst %b expected 1 0 1",
                  err, busy, cpu_rst);
      end
      for (int k = 0; k < 4; k++) tick();
      n_assert++;
      if (wa.size() != 0) begin
         n_fail++;
         $display("FAIL len257_writes: got %0d expected 0", wa.size());
      end
      clear_log();
      tx.delete();
      for (int k = 0; k < 256; k++) begin
         tx.push_back(8'(k));
         tx.push_back(~8'(k));
      end
      start(9'd256);
      send_bytes(1'b0);
      wait_done();
      tick();
      n_assert++;
      if (wa.size() != 256) begin
         n_fail++;
         $display("FAIL full_count: got %0d expected 256", wa.size());
      end else begin
         for (int k = 0; k < 256; k++) begin
            n_assert++;
            if (wa[k] !== 8'(k) || wd[k] !== {8'(k), ~8'(k)}) begin
               n_fail++;
               bad++;
               if (bad < 8)
                  $display("FAIL full_write%0d: got %h/%h expected %h/%h",
                           k, wa[k], wd[k], 8'(k), {8'(k), ~8'(k)});
            end
         end
         n_assert++;
         if (wa[255] !== 8'hFF || fall_cyc - wc[255] != 3) begin
            n_fail++;
            $display("FAIL full_last: addr %h delay %0d expected ff 3",
                     wa[255], fall_cyc - wc[255]);
         end
      end
      n_assert++;
      if (cpu_rst !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL full_run: cpu_rst %b err %b expected 0 0",
                  cpu_rst, err);
      end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_gaps();
      test_reload();
      test_abort();
      test_bounds();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
